// File: rtl/neomatrix_axil_regs.sv
// AXI4-Lite register bank for NeoMatrix: three R/W control registers plus one read-only status word.
// Write address and write data are buffered independently, so they may arrive in either order.
module neomatrix_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] C_REG0_RESET       = 32'h0,
    parameter logic [31:0] C_REG1_RESET       = 32'h0,
    parameter logic [31:0] C_REG2_RESET       = 32'h0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [2:0]                      reg_wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_i
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [DW-1:0] REG_RESET [3] = '{C_REG0_RESET, C_REG1_RESET, C_REG2_RESET};

    logic          r_aw_full;
    logic [1:0]    r_aw_idx;
    logic          r_w_full;
    logic [DW-1:0] r_w_data;
    logic [NB-1:0] r_w_strb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [2:0]    r_wr_pulse;

    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_commit;
    logic [1:0]    w_wr_idx;
    logic [DW-1:0] w_wr_data;
    logic [NB-1:0] w_wr_strb;
    logic [2:0]    w_wr_sel;
    logic [DW-1:0] w_regs [3];
    logic [DW-1:0] w_rd_mux;
    logic          w_unused_ok;

    assign S_AXI_AWREADY = !r_aw_full && !r_bvalid;
    assign S_AXI_WREADY  = !r_w_full && !r_bvalid;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = !r_rvalid;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign reg_wr_pulse  = r_wr_pulse;
    assign reg0_o        = w_regs[0];
    assign reg1_o        = w_regs[1];
    assign reg2_o        = w_regs[2];

    assign w_aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    // A commit needs both halves; since buffers never both fill, one side always handshakes now.
    assign w_commit  = (w_aw_hs || r_aw_full) && (w_w_hs || r_w_full);
    assign w_wr_idx  = w_aw_hs ? S_AXI_AWADDR[3:2] : r_aw_idx;
    assign w_wr_data = w_w_hs ? S_AXI_WDATA : r_w_data;
    assign w_wr_strb = w_w_hs ? S_AXI_WSTRB : r_w_strb;

    assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_full  <= 1'b0;
            r_aw_idx   <= 2'd0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= 3'b000;
        end else begin
            r_wr_pulse <= w_commit ? w_wr_sel : 3'b000;
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_wr_idx == 2'd3) ? 2'b10 : 2'b00;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
                if (r_bvalid && S_AXI_BREADY) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_reg
            logic [DW-1:0] r_reg;

            assign w_wr_sel[gi] = (w_wr_idx == 2'(gi));
            assign w_regs[gi]   = r_reg;

            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    r_reg <= REG_RESET[gi];
                end else if (w_commit && w_wr_sel[gi]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_wr_strb[b]) begin
                            r_reg[8*b +: 8] <= w_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_rd_mux = status_i;
        case (S_AXI_ARADDR[3:2])
            2'd0:    w_rd_mux = w_regs[0];
            2'd1:    w_rd_mux = w_regs[1];
            2'd2:    w_rd_mux = w_regs[2];
            default: w_rd_mux = status_i;
        endcase
    end

    // Read data is sampled from pre-commit register state, so a same-edge write is not visible.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (S_AXI_ARVALID && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule
